// File: rtl/exc_pkg.sv
// Shared definitions for the exception controller: FSM states, cause codes
// and fetch PC-source encodings.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_VECT = 2'd2,
    ST_RET  = 2'd3
  } exc_state_e;

  localparam int unsigned CAUSE_SYS      = 32'd8;
  localparam int unsigned CAUSE_ILL      = 32'd10;
  localparam int unsigned CAUSE_PRIV     = 32'd11;
  localparam int unsigned CAUSE_OVF      = 32'd12;
  localparam int unsigned CAUSE_IRQ_BASE = 32'd16;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_VEC = 2'b01;
  localparam logic [1:0] PC_SEL_EPC = 2'b10;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the highest-priority pending event
// and reports its cause code plus a one-hot IRQ select.
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NIRQ    = 4,
  parameter int CAUSE_W = 5
) (
  input  logic               ill,
  input  logic               priv_viol,
  input  logic               ovf,
  input  logic               syscall,
  input  logic [NIRQ-1:0]    irq_req,
  output logic               valid,
  output logic [CAUSE_W-1:0] cause,
  output logic [NIRQ-1:0]    irq_sel
);

  // Fixed priority: ILL > PRIV > OVF > SYS > IRQ (lowest index first).
  always_comb begin
    valid   = 1'b0;
    cause   = '0;
    irq_sel = '0;
    if (ill) begin
      valid = 1'b1;
      cause = CAUSE_W'(CAUSE_ILL);
    end else if (priv_viol) begin
      valid = 1'b1;
      cause = CAUSE_W'(CAUSE_PRIV);
    end else if (ovf) begin
      valid = 1'b1;
      cause = CAUSE_W'(CAUSE_OVF);
    end else if (syscall) begin
      valid = 1'b1;
      cause = CAUSE_W'(CAUSE_SYS);
    end else begin
      for (int i = 0; i < NIRQ; i++) begin
        if (irq_req[i] && !valid) begin
          valid      = 1'b1;
          cause      = CAUSE_W'(CAUSE_IRQ_BASE + 32'(i));
          irq_sel[i] = 1'b1;
        end else begin
          valid = valid;
        end
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller feeding the status register and fetch PC mux.
// Optional build macro EXC_IRQ_EDGE_EN selects edge-captured pending IRQs.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          NIRQ     = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0080,
  parameter int          CAUSE_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NIRQ-1:0]    irq_in,
  input  logic               ill_inst,
  input  logic               priv_inst,
  input  logic               ovf,
  input  logic               syscall,
  input  logic               rfe_dec,
  input  logic [31:0]        pc_in,
  input  logic               stall,
  input  logic               IE_c,
  input  logic               s_u_c,
  output logic               exception,
  output logic               rfe,
  output logic               flush,
  output logic [1:0]         pc_sel,
  output logic [31:0]        vec_addr,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] cause,
  output logic [NIRQ-1:0]    irq_ack,
  output logic               busy
);

  exc_state_e state_q, state_d;
  logic [31:0]        epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  logic               exception_q, exception_d;
  logic               rfe_q, rfe_d;
  logic               flush_q, flush_d;
  logic               busy_q, busy_d;
  logic [1:0]         pc_sel_q, pc_sel_d;
  logic [31:0]        vec_addr_q, vec_addr_d;
  logic [NIRQ-1:0]    irq_ack_q, irq_ack_d;

  logic [NIRQ-1:0]    irq_src_s;
  logic [NIRQ-1:0]    irq_req_s;
  logic               priv_viol_s;
  logic               evt_valid_s;
  logic [CAUSE_W-1:0] evt_cause_s;
  logic [NIRQ-1:0]    evt_irq_sel_s;

`ifdef EXC_IRQ_EDGE_EN
  logic [NIRQ-1:0] irq_prev_q;
  logic [NIRQ-1:0] irq_pend_q, irq_pend_d;

  // Latch rising edges; the acknowledge of the taken line clears its bit.
  always_comb begin
    irq_pend_d = (irq_pend_q | (irq_in & ~irq_prev_q)) & ~irq_ack_q;
    irq_src_s  = irq_pend_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_prev_q <= '0;
      irq_pend_q <= '0;
    end else begin
      irq_prev_q <= irq_in;
      irq_pend_q <= irq_pend_d;
    end
  end
`else
  assign irq_src_s = irq_in;
`endif

  always_comb begin
    if (IE_c) begin
      irq_req_s = irq_src_s;
    end else begin
      irq_req_s = '0;
    end
  end

  // An rfe issued from user mode is itself a privilege violation.
  assign priv_viol_s = (priv_inst | rfe_dec) & ~s_u_c;

  exc_prio_enc #(
    .NIRQ    (NIRQ),
    .CAUSE_W (CAUSE_W)
  ) u_prio_enc (
    .ill       (ill_inst),
    .priv_viol (priv_viol_s),
    .ovf       (ovf),
    .syscall   (syscall),
    .irq_req   (irq_req_s),
    .valid     (evt_valid_s),
    .cause     (evt_cause_s),
    .irq_sel   (evt_irq_sel_s)
  );

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (stall) begin
          state_d = ST_IDLE;
        end else if (evt_valid_s) begin
          epc_d   = pc_in;
          cause_d = evt_cause_s;
          state_d = ST_TRAP;
        end else if (rfe_dec && s_u_c) begin
          state_d = ST_RET;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TRAP: state_d = ST_VECT;
      ST_VECT: state_d = ST_IDLE;
      ST_RET:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave flops aligned with it.
  always_comb begin
    exception_d = (state_d == ST_TRAP);
    rfe_d       = (state_d == ST_RET);
    flush_d     = exception_d | rfe_d;
    busy_d      = (state_d != ST_IDLE);
    irq_ack_d   = '0;
    if (exception_d) begin
      irq_ack_d = evt_irq_sel_s;
    end else begin
      irq_ack_d = '0;
    end
    case (state_d)
      ST_VECT: pc_sel_d = PC_SEL_VEC;
      ST_RET:  pc_sel_d = PC_SEL_EPC;
      default: pc_sel_d = PC_SEL_SEQ;
    endcase
    vec_addr_d = VEC_BASE + {{(29 - CAUSE_W){1'b0}}, cause_d, 3'b000};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      epc_q       <= 32'h0000_0000;
      cause_q     <= '0;
      exception_q <= 1'b0;
      rfe_q       <= 1'b0;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      pc_sel_q    <= PC_SEL_SEQ;
      vec_addr_q  <= VEC_BASE;
      irq_ack_q   <= '0;
    end else begin
      state_q     <= state_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      exception_q <= exception_d;
      rfe_q       <= rfe_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      pc_sel_q    <= pc_sel_d;
      vec_addr_q  <= vec_addr_d;
      irq_ack_q   <= irq_ack_d;
    end
  end

  assign exception = exception_q;
  assign rfe       = rfe_q;
  assign flush     = flush_q;
  assign busy      = busy_q;
  assign pc_sel    = pc_sel_q;
  assign vec_addr  = vec_addr_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign irq_ack   = irq_ack_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl; inputs change and outputs are
// sampled on the falling clock edge.
module tb_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_in;
  logic        ill_inst;
  logic        priv_inst;
  logic        ovf;
  logic        syscall;
  logic        rfe_dec;
  logic [31:0] pc_in;
  logic        stall;
  logic        IE_c;
  logic        s_u_c;
  logic        exception;
  logic        rfe;
  logic        flush;
  logic [1:0]  pc_sel;
  logic [31:0] vec_addr;
  logic [31:0] epc;
  logic [4:0]  cause;
  logic [3:0]  irq_ack;
  logic        busy;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(
    .NIRQ     (4),
    .VEC_BASE (32'h0000_0080),
    .CAUSE_W  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .ill_inst  (ill_inst),
    .priv_inst (priv_inst),
    .ovf       (ovf),
    .syscall   (syscall),
    .rfe_dec   (rfe_dec),
    .pc_in     (pc_in),
    .stall     (stall),
    .IE_c      (IE_c),
    .s_u_c     (s_u_c),
    .exception (exception),
    .rfe       (rfe),
    .flush     (flush),
    .pc_sel    (pc_sel),
    .vec_addr  (vec_addr),
    .epc       (epc),
    .cause     (cause),
    .irq_ack   (irq_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'b0000; ill_inst = 1'b0; priv_inst = 1'b0;
    ovf = 1'b0; syscall = 1'b0; rfe_dec = 1'b0; pc_in = 32'h0;
    stall = 1'b0; IE_c = 1'b1; s_u_c = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc_sel", 32'(pc_sel), 32'h0);
    chk("rst_exc", 32'(exception), 32'h0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_vec", vec_addr, 32'h80);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    tick();
    chk("rel_pc_sel", 32'(pc_sel), 32'h0);
    chk("rel_vec", vec_addr, 32'h80);

    // Illegal instruction
    ill_inst = 1'b1; pc_in = 32'h100;
    tick();
    chk("ill_exc", 32'(exception), 32'h1);
    chk("ill_flush", 32'(flush), 32'h1);
    chk("ill_cause", 32'(cause), 32'd10);
    chk("ill_epc", epc, 32'h100);
    chk("ill_ack", 32'(irq_ack), 32'h0);
    ill_inst = 1'b0; pc_in = 32'h104;
    tick();
    chk("ill_vect_exc", 32'(exception), 32'h0);
    chk("ill_vect_sel", 32'(pc_sel), 32'h1);
    chk("ill_vect_addr", vec_addr, 32'hD0);
    tick();
    chk("ill_idle_sel", 32'(pc_sel), 32'h0);
    chk("ill_idle_busy", 32'(busy), 32'h0);
    chk("ill_epc_hold", epc, 32'h100);

    // IRQ, lowest index wins
    irq_in = 4'b0110; IE_c = 1'b1; pc_in = 32'h200;
`ifdef EXC_IRQ_EDGE_EN
    tick();
`endif
    tick();
    chk("irq_exc", 32'(exception), 32'h1);
    chk("irq_cause", 32'(cause), 32'd17);
    chk("irq_ack", 32'(irq_ack), 32'h2);
    irq_in = 4'b0000;
    tick();
    chk("irq_vect_addr", vec_addr, 32'h108);
    chk("irq_vect_ack", 32'(irq_ack), 32'h0);
    tick();
`ifdef EXC_IRQ_EDGE_EN
    tick();
    chk("irq_pend2_cause", 32'(cause), 32'd18);
    chk("irq_pend2_ack", 32'(irq_ack), 32'h4);
    tick();
    tick();
`endif

    // IRQ masked
    IE_c = 1'b0; irq_in = 4'b0110;
    tick();
    chk("irq_mask_exc", 32'(exception), 32'h0);
    tick();
    chk("irq_mask_busy", 32'(busy), 32'h0);
    irq_in = 4'b0000;
`ifdef EXC_IRQ_EDGE_EN
    IE_c = 1'b1;
    tick();
    chk("drain1_cause", 32'(cause), 32'd17);
    tick(); tick(); tick();
    chk("drain2_cause", 32'(cause), 32'd18);
    tick(); tick();
    IE_c = 1'b0;
`endif

    // Legal rfe from supervisor
    s_u_c = 1'b1; rfe_dec = 1'b1; pc_in = 32'h300;
    tick();
    chk("rfe_pulse", 32'(rfe), 32'h1);
    chk("rfe_flush", 32'(flush), 32'h1);
    chk("rfe_sel", 32'(pc_sel), 32'h2);
    chk("rfe_exc", 32'(exception), 32'h0);
    chk("rfe_epc_hold", epc, 32'h200);
    rfe_dec = 1'b0;
    tick();
    chk("rfe_done", 32'(rfe), 32'h0);
    chk("rfe_done_sel", 32'(pc_sel), 32'h0);

    // rfe from user mode traps as PRIV
    s_u_c = 1'b0; rfe_dec = 1'b1; pc_in = 32'h400;
    tick();
    chk("urfe_exc", 32'(exception), 32'h1);
    chk("urfe_cause", 32'(cause), 32'd11);
    chk("urfe_rfe", 32'(rfe), 32'h0);
    chk("urfe_epc", epc, 32'h400);
    rfe_dec = 1'b0; s_u_c = 1'b1;
    tick(); tick();

    // Privileged instruction in supervisor mode is legal
    priv_inst = 1'b1;
    tick();
    chk("priv_sup_exc", 32'(exception), 32'h0);
    priv_inst = 1'b0;

    // OVF + SYS under stall
    ovf = 1'b1; syscall = 1'b1; stall = 1'b1; pc_in = 32'h500;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_exc", 32'(exception), 32'h0);
      chk("stall_epc", epc, 32'h400);
    end
    stall = 1'b0;
    tick();
    chk("ovf_exc", 32'(exception), 32'h1);
    chk("ovf_cause", 32'(cause), 32'd12);
    chk("ovf_epc", epc, 32'h500);
    ovf = 1'b0; syscall = 1'b0;
    tick();
    chk("ovf_vect_addr", vec_addr, 32'hE0);
    tick();

    // Exception beats a legal rfe
    ill_inst = 1'b1; rfe_dec = 1'b1; s_u_c = 1'b1; pc_in = 32'h580;
    tick();
    chk("ill_rfe_exc", 32'(exception), 32'h1);
    chk("ill_rfe_rfe", 32'(rfe), 32'h0);
    chk("ill_rfe_cause", 32'(cause), 32'd10);
    ill_inst = 1'b0; rfe_dec = 1'b0;
    tick(); tick();

    // Reset during TRAP
    ill_inst = 1'b1; pc_in = 32'h600;
    tick();
    chk("pre_rst_exc", 32'(exception), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_exc", 32'(exception), 32'h0);
    chk("midrst_flush", 32'(flush), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_epc", epc, 32'h0);
    chk("midrst_vec", vec_addr, 32'h80);
    ill_inst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("postrst_exc", 32'(exception), 32'h0);
    chk("postrst_sel", 32'(pc_sel), 32'h0);

`ifdef EXC_IRQ_EDGE_EN
    // Short pulse while masked is remembered
    IE_c = 1'b0; irq_in = 4'b1000;
    tick();
    irq_in = 4'b0000;
    tick(); tick();
    chk("pulse_masked_exc", 32'(exception), 32'h0);
    IE_c = 1'b1;
    tick();
    chk("pulse_exc", 32'(exception), 32'h1);
    chk("pulse_cause", 32'(cause), 32'd19);
    chk("pulse_ack", 32'(irq_ack), 32'h8);
    tick(); tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller directly upstream of the status register.
- Collects synchronous faults and external interrupt requests, and qualifies them against the status register's IE_c/s_u_c outputs.
- Drives the status register's one-cycle `exception` and `rfe` pulses.
- Captures EPC and cause, and steers the fetch stage to the handler vector or back to EPC.

Parameters:
- NIRQ, 4: number of external interrupt lines (1..8).
- VEC_BASE, 32'h0000_0080: handler vector base address.
- CAUSE_W, 5: cause code width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset.
- irq_in  in  NIRQ  external interrupt request levels.
- ill_inst  in  1  decode: illegal instruction.
- priv_inst  in  1  decode: privileged instruction.
- ovf  in  1  execute: arithmetic overflow trap.
- syscall  in  1  decode: system call.
- rfe_dec  in  1  decode: return-from-exception instruction.
- pc_in  in  32  PC of the instruction currently in decode.
- stall  in  1  pipeline stall; no event is accepted while high.
- IE_c  in  1  interrupt enable, from the status register.
- s_u_c  in  1  mode, from the status register: 1 = supervisor, 0 = user.
- exception  out  1  one-cycle pulse to the status register.
- rfe  out  1  one-cycle pulse to the status register.
- flush  out  1  squash the fetch/decode/execute stages.
- pc_sel  out  2  PC source: 00 = sequential, 01 = vector, 10 = EPC.
- vec_addr  out  32  handler address.
- epc  out  32  saved exception PC.
- cause  out  CAUSE_W  latched cause code.
- irq_ack  out  NIRQ  one-hot, one-cycle acknowledge of the taken IRQ.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - epc=0, cause=0, irq_pend=0.
  - All pulse outputs and flush are 0; pc_sel=00; busy=0.
  - vec_addr = VEC_BASE.
- Cause codes (CAUSE_W bits):
  - IRQ i = 16+i.
  - SYS = 8.
  - ILL = 10.
  - PRIV = 11.
  - OVF = 12.
- Privilege violation: priv_inst & !s_u_c, or rfe_dec & !s_u_c.
- Priority, evaluated in IDLE with stall=0 (highest first):
  1. ILL
  2. PRIV
  3. OVF
  4. SYS
  5. IRQ, lowest index first
- IRQ gating: an IRQ is taken only when IE_c=1. Synchronous faults are taken regardless of IE_c.
- States:
  - IDLE:
    - On a qualifying event, register epc <= pc_in and cause <= code, then go to TRAP.
    - Otherwise, if rfe_dec & s_u_c, go to RET.
  - TRAP (1 cycle):
    - exception=1, flush=1.
    - irq_ack bit set if the event is an IRQ.
    - Go to VECT.
  - VECT (1 cycle):
    - pc_sel=01, vec_addr = VEC_BASE + {cause, 3'b000}.
    - Return to IDLE.
  - RET (1 cycle):
    - rfe=1, flush=1, pc_sel=10.
    - Return to IDLE.
- Latency: event in IDLE at edge N → exception pulse at N+1 → vector fetch at N+2.
- Simultaneous events:
  - An exception and a legal rfe together: the exception wins; rfe is dropped.
  - Multiple sources: only the highest-priority source is recorded. Lower-priority IRQs stay pending; synchronous faults are squashed by the flush.
- All inputs are ignored in TRAP, VECT and RET; busy=1 in these states.
- stall=1 in IDLE: no transition; epc and cause hold.
- epc and cause hold their values until the next accepted exception; RET does not alter them.
- Nesting: after a trap the status register clears IE, so IRQs are masked until rfe. Synchronous faults inside a handler still trap and overwrite epc.
- Reset mid-sequence: immediate return to IDLE with no stray pulses.

Optional Feature:
- Macro: EXC_IRQ_EDGE_EN.
- Defined:
  - irq_pend[i] is set on a rising edge of irq_in[i] (1-cycle delayed sample, compared with the current value).
  - irq_pend[i] is cleared by irq_ack[i].
  - Pending bits are evaluated in place of irq_in, so a short pulse arriving while IE_c=0 is taken later.
- Undefined: level-sensitive; irq_in is used directly and irq_pend is absent.

Decomposition:
- Shared package exc_pkg holds:
  - state encoding (IDLE/TRAP/VECT/RET)
  - cause code constants
  - pc_sel encodings
- One sub-module, exc_prio_enc: combinational priority encoder producing the valid flag, cause code and one-hot IRQ select.

Test Plan:
- Reset release → pc_sel=00, exception=0, epc=0, vec_addr=32'h80.
- ill_inst=1, pc_in=32'h100, stall=0 → exception pulse 1 cycle later; cause=10; epc=32'h100; next cycle pc_sel=01 with vec_addr=32'hD0.
- irq_in=4'b0110, IE_c=1 → cause=17 and irq_ack=4'b0010. With IE_c=0 → no exception.
- rfe_dec=1 with s_u_c=1 → rfe pulse and pc_sel=10. With s_u_c=0 → exception with cause=11.
- ovf=1 and syscall=1 together, stall=1 for 3 cycles then 0 → trap fires only after the stall drops; cause=12.
- rst asserted during TRAP → all outputs return to reset values the same cycle. With EXC_IRQ_EDGE_EN, a 1-cycle irq_in[3] pulse while IE_c=0 is taken once IE_c=1 (cause=19).
